// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: multiplexed address/data bus-cycle generator for an external RTC.
//
// A processor strobe qualified by act_rtc starts one transaction: an address phase,
// a gap, a data phase (write drives wdat, read samples ad_in), a second gap and a
// one-cycle done pulse. Requests that arrive while busy are dropped with a pulse.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   act_rtc, dir          RTC enable and register address from the port-ID decoder
//   write_strobe,
//   read_strobe, data_in  processor strobes and output-port data
//   rd_data               last byte read from the RTC
//   busy, done, drop      status: in progress, completion pulse, rejected-request pulse
//   cs_n, a_d, rd_n, wr_n RTC bus control strobes (registered)
//   ad_out, ad_oe, ad_in  multiplexed bus value, output enable, sampled value
module rtc_bus_ctrl #(
    parameter int unsigned PHASE_CYC = 10,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       act_rtc,
    input  logic [7:0] dir,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] data_in,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       drop,
    output logic       cs_n,
    output logic       a_d,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [7:0] PhaseLoad = 8'(PHASE_CYC - 1);
    localparam logic [7:0] GapLoad   = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StGapA, StData, StGapD, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdat_q, wdat_d;
    logic       is_rd_q, is_rd_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       cs_n_q, cs_n_d;
    logic       a_d_q, a_d_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ad_oe_q, ad_oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       drop_q, drop_d;
    logic       req;

    assign req = act_rtc & (write_strobe | read_strobe);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        is_rd_d   = is_rd_q;
        rd_data_d = rd_data_q;
        drop_d    = req & (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StAddr;
                    cnt_d   = PhaseLoad;
                    addr_d  = dir;
                    wdat_d  = data_in;
                    is_rd_d = read_strobe & ~write_strobe;
                end
            end
            StAddr: begin
                if (cnt_q == 8'd0) begin
                    state_d = StGapA;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StGapA: begin
                if (cnt_q == 8'd0) begin
                    state_d = StData;
                    cnt_d   = PhaseLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StData: begin
                if (cnt_q == 8'd0) begin
                    // Sample the RTC as late as possible in the read strobe.
                    if (is_rd_q) begin
                        rd_data_d = ad_in;
                    end
                    state_d = StGapD;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StGapD: begin
                if (cnt_q == 8'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus outputs are decoded from the next state so they are registered
        // and line up with the state they belong to.
        cs_n_d   = 1'b1;
        a_d_d    = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        unique case (state_d)
            StAddr: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            StData: begin
                cs_n_d = 1'b0;
                if (is_rd_d) begin
                    rd_n_d = 1'b0;  // bus released while the RTC drives it
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdat_d;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            addr_q    <= 8'd0;
            wdat_q    <= 8'd0;
            is_rd_q   <= 1'b0;
            rd_data_q <= 8'd0;
            ad_out_q  <= 8'd0;
            cs_n_q    <= 1'b1;
            a_d_q     <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            is_rd_q   <= is_rd_d;
            rd_data_q <= rd_data_d;
            ad_out_q  <= ad_out_d;
            cs_n_q    <= cs_n_d;
            a_d_q     <= a_d_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_oe_q   <= ad_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign drop    = drop_q;
    assign cs_n    = cs_n_q;
    assign a_d     = a_d_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign ad_out  = ad_out_q;
    assign ad_oe   = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: a default-parameter instance and a P=G=1 instance share
// data inputs but have separate act_rtc enables. Expected bus behaviour is derived
// from the phase timeline (cycle offset from the accepting edge).
module tb_rtc_bus_ctrl;

    localparam int P = 10;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       act_main, act_min;
    logic       write_strobe, read_strobe;
    logic [7:0] dir, data_in, ad_in;

    logic [7:0] m_rd_data, m_ad_out, n_rd_data, n_ad_out;
    logic m_busy, m_done, m_drop, m_cs_n, m_a_d, m_rd_n, m_wr_n, m_ad_oe;
    logic n_busy, n_done, n_drop, n_cs_n, n_a_d, n_rd_n, n_wr_n, n_ad_oe;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rd_exp [2];

    always #5 clk = ~clk;

    rtc_bus_ctrl u_dut (
        .clk(clk), .reset(reset), .act_rtc(act_main), .dir(dir),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .data_in(data_in),
        .rd_data(m_rd_data), .busy(m_busy), .done(m_done), .drop(m_drop),
        .cs_n(m_cs_n), .a_d(m_a_d), .rd_n(m_rd_n), .wr_n(m_wr_n),
        .ad_out(m_ad_out), .ad_oe(m_ad_oe), .ad_in(ad_in)
    );

    rtc_bus_ctrl #(.PHASE_CYC(1), .GAP_CYC(1)) u_min (
        .clk(clk), .reset(reset), .act_rtc(act_min), .dir(dir),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .data_in(data_in),
        .rd_data(n_rd_data), .busy(n_busy), .done(n_done), .drop(n_drop),
        .cs_n(n_cs_n), .a_d(n_a_d), .rd_n(n_rd_n), .wr_n(n_wr_n),
        .ad_out(n_ad_out), .ad_oe(n_ad_oe), .ad_in(ad_in)
    );

    // Flag vector order: {cs_n, a_d, rd_n, wr_n, ad_oe, busy, done, drop}
    function automatic logic [7:0] get_flags(input int mn);
        if (mn != 0) return {n_cs_n, n_a_d, n_rd_n, n_wr_n, n_ad_oe, n_busy, n_done, n_drop};
        return {m_cs_n, m_a_d, m_rd_n, m_wr_n, m_ad_oe, m_busy, m_done, m_drop};
    endfunction

    function automatic logic [7:0] get_ad_out(input int mn);
        return (mn != 0) ? n_ad_out : m_ad_out;
    endfunction

    function automatic logic [7:0] get_rd_data(input int mn);
        return (mn != 0) ? n_rd_data : m_rd_data;
    endfunction

    // Expected flags k cycles after the accepting edge (k<1 or past done: idle).
    function automatic logic [7:0] exp_flags(input int k, input int p, input int g,
                                             input bit rd, input bit drp);
        logic [6:0] f;
        if (k < 1)                    f = 7'b1111000;
        else if (k <= p)              f = 7'b0010110;
        else if (k <= p + g)          f = 7'b1111010;
        else if (k <= 2 * p + g)      f = rd ? 7'b0101010 : 7'b0110110;
        else if (k <= 2 * p + 2 * g)  f = 7'b1111010;
        else if (k == 2 * p + 2 * g + 1) f = 7'b1111011;
        else                          f = 7'b1111000;
        return {f, drp};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int mn, input string name);
        logic [7:0] got;
        got = get_flags(mn);
        n_cmp++;
        if (got !== 8'b11110000) begin
            n_bad++;
            $display("FAIL %s idle flags: got %b expected 11110000", name, got);
        end
        n_cmp++;
        if (get_rd_data(mn) !== rd_exp[mn]) begin
            n_bad++;
            $display("FAIL %s rd_data: got %h expected %h", name, get_rd_data(mn), rd_exp[mn]);
        end
    endtask

    // One full transaction from request to the first idle cycle after done.
    // drop_at>0 pulses read_strobe during that cycle offset (expect drop one cycle later).
    task automatic run_txn(input int mn, input bit rs, input bit ws, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] bus, input int drop_at,
                           input string name);
        int p, g, last;
        bit is_rd;
        logic [7:0] fe, fg;
        p = (mn != 0) ? 1 : P;
        g = (mn != 0) ? 1 : G;
        last = 2 * p + 2 * g + 1;
        is_rd = rs & ~ws;
        dir = a; data_in = d; read_strobe = rs; write_strobe = ws;
        if (mn != 0) act_min = 1'b1; else act_main = 1'b1;
        ad_in = ~bus;
        step();
        read_strobe = 1'b0; write_strobe = 1'b0;
        dir = 8'($urandom); data_in = 8'($urandom);  // must already be latched
        for (int k = 1; k <= last + 1; k++) begin
            if (is_rd && k == 2 * p + g + 1) rd_exp[mn] = bus;
            fe = exp_flags(k, p, g, is_rd, (drop_at > 0) && (k == drop_at + 1));
            fg = get_flags(mn);
            n_cmp++;
            if (fg !== fe) begin
                n_bad++;
                $display("FAIL %s flags k=%0d: got %b expected %b", name, k, fg, fe);
            end
            if (fe[3]) begin
                n_cmp++;
                if (get_ad_out(mn) !== ((k <= p) ? a : d)) begin
                    n_bad++;
                    $display("FAIL %s ad_out k=%0d: got %h expected %h", name, k,
                             get_ad_out(mn), (k <= p) ? a : d);
                end
            end
            n_cmp++;
            if (get_rd_data(mn) !== rd_exp[mn]) begin
                n_bad++;
                $display("FAIL %s rd_data k=%0d: got %h expected %h", name, k,
                         get_rd_data(mn), rd_exp[mn]);
            end
            read_strobe = (k == drop_at);
            ad_in = (k == 2 * p + g) ? bus : ~bus;
            if (k <= last) step();
        end
        read_strobe = 1'b0; act_main = 1'b0; act_min = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        check_idle(0, "reset_main");
        check_idle(1, "reset_min");
        n_cmp++;
        if (m_ad_out !== 8'h00 || n_ad_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset ad_out: got %h/%h expected 00", m_ad_out, n_ad_out);
        end
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        step();
        check_idle(0, "post_reset");
    endtask

    task automatic test_disabled();
        act_main = 1'b0; act_min = 1'b0;
        write_strobe = 1'b1; read_strobe = 1'b1;
        step();
        write_strobe = 1'b0; read_strobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle(0, "disabled_main");
            check_idle(1, "disabled_min");
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fg;
        act_main = 1'b1; dir = 8'h5a; data_in = 8'hc3; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; act_main = 1'b0;
        for (int k = 1; k < 18; k++) step();
        #1 reset = 1'b1;
        #1;
        rd_exp[0] = 8'h00; rd_exp[1] = 8'h00;
        fg = get_flags(0);
        n_cmp++;
        if (fg !== 8'b11110000 || m_ad_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid async: got %b/%h expected 11110000/00", fg, m_ad_out);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        for (int i = 0; i < 2 * P + 2 * G + 3; i++) begin
            check_idle(0, "reset_mid_nodone");
            step();
        end
        run_txn(0, 1'b0, 1'b1, 8'h33, 8'h44, 8'h00, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_txn(0, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00, 2 * P + 2 * G + 1, "b2b_first");
        run_txn(0, 1'b1, 1'b0, 8'h11, 8'h00, 8'h99, 0, "b2b_second");
    endtask

    task automatic test_random();
        int mn, p, g, last, da, sel;
        bit rs, ws;
        for (int i = 0; i < 10; i++) begin
            mn = int'($urandom_range(1, 0));
            p = (mn != 0) ? 1 : P;
            g = (mn != 0) ? 1 : G;
            last = 2 * p + 2 * g + 1;
            sel = int'($urandom_range(2, 0));
            rs = (sel != 1);
            ws = (sel != 0);
            da = ($urandom_range(1, 0) != 0) ? int'($urandom_range(last, 2)) : 0;
            run_txn(mn, rs, ws, 8'($urandom), 8'($urandom), 8'($urandom), da, "random");
            for (int j = int'($urandom_range(3, 0)); j > 0; j--) step();
        end
    endtask

    initial begin
        act_main = 1'b0; act_min = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
        dir = 8'h00; data_in = 8'h00; ad_in = 8'h00;
        rd_exp[0] = 8'h00; rd_exp[1] = 8'h00;
        test_reset();
        run_txn(0, 1'b0, 1'b1, 8'h21, 8'h45, 8'h77, 0, "write");
        run_txn(0, 1'b1, 1'b0, 8'h23, 8'h00, 8'h12, 0, "read");
        run_txn(0, 1'b0, 1'b1, 8'h2a, 8'h6b, 8'h00, 5, "busy_reject");
        run_txn(0, 1'b1, 1'b1, 8'h31, 8'h9e, 8'h55, 0, "both_strobes");
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        run_txn(1, 1'b1, 1'b0, 8'h07, 8'h00, 8'hb4, 0, "min_read");
        run_txn(1, 1'b0, 1'b1, 8'h08, 8'he1, 8'h00, 0, "min_write");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
